// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 encodings, FSM state type
// and the small decode helpers used by both the FSM and the lane aligner.
package lsu_pkg;

  localparam logic [2:0] F3_B       = 3'b000;
  localparam logic [2:0] F3_H       = 3'b001;
  localparam logic [2:0] F3_W       = 3'b010;
  localparam logic [2:0] F3_D       = 3'b011;
  localparam logic [2:0] F3_BU      = 3'b100;
  localparam logic [2:0] F3_HU      = 3'b101;
  localparam logic [2:0] F3_WU      = 3'b110;
  localparam logic [2:0] F3_ILLEGAL = 3'b111;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_READ    = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_WRITE   = 3'd3,
    ST_RESP    = 3'd4
  } lsu_state_t;

  // Misalignment, the reserved 111 encoding and unsigned-store encodings all fault.
  function automatic logic req_fault(input logic write, input logic [2:0] funct3,
                                     input logic [2:0] offset);
    logic fault;
    fault = 1'b0;
    case (funct3[1:0])
      2'b00:   fault = 1'b0;
      2'b01:   fault = offset[0];
      2'b10:   fault = (offset[1:0] != 2'b00);
      2'b11:   fault = (offset != 3'b000) || funct3[2];
      default: fault = 1'b1;
    endcase
    return fault | (write & funct3[2]);
  endfunction

  function automatic logic [7:0] size_mask(input logic [1:0] size);
    logic [7:0] mask;
    case (size)
      2'b00:   mask = 8'h01;
      2'b01:   mask = 8'h03;
      2'b10:   mask = 8'h0F;
      2'b11:   mask = 8'hFF;
      default: mask = 8'h00;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/lsu_if.sv
// Bundle of the core-side handshake and the data_memory bus of the load/store unit.
interface lsu_if #(parameter int XLEN = 64) ();

  logic            req_valid;
  logic            req_ready;
  logic            req_write;
  logic [2:0]      req_funct3;
  logic [XLEN-1:0] req_addr;
  logic [XLEN-1:0] req_wdata;
  logic            resp_valid;
  logic [XLEN-1:0] resp_rdata;
  logic            resp_fault;
  logic [XLEN-1:0] mem_address;
  logic [XLEN-1:0] mem_write_data;
  logic            mem_write_en;
  logic            mem_read_en;
  logic [XLEN-1:0] mem_read_data;

  modport core (
    output req_valid, req_write, req_funct3, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_fault
  );

  modport lsu (
    input  req_valid, req_write, req_funct3, req_addr, req_wdata, mem_read_data,
    output req_ready, resp_valid, resp_rdata, resp_fault,
           mem_address, mem_write_data, mem_write_en, mem_read_en
  );

  modport mem_side (
    input  mem_address, mem_write_data, mem_write_en, mem_read_en,
    output mem_read_data
  );

endinterface

// File: rtl/data_memory.sv
// Small doubleword-wide data memory with one-cycle registered read, paired with
// the load/store unit. Contents are deliberately not cleared by reset.
module data_memory #(
  parameter int XLEN       = 64,
  parameter int DEPTH_LOG2 = 5
) (
  input  logic   clk,
  input  logic   rstn,
  lsu_if.mem_side bus
);

  logic [XLEN-1:0]       mem [2**DEPTH_LOG2];
  logic [DEPTH_LOG2-1:0] idx;
  logic                  hit;

  assign idx = bus.mem_address[3 +: DEPTH_LOG2];
  assign hit = (bus.mem_address[XLEN-1:3+DEPTH_LOG2] == '0) &&
               (bus.mem_address[2:0] == 3'b000);

  // Storage array write port.
  always_ff @(posedge clk) begin
    if (bus.mem_write_en && hit) begin
      mem[idx] <= bus.mem_write_data;
    end
  end

  // Registered read port; data appears the cycle after mem_read_en.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      bus.mem_read_data <= '0;
    end else if (bus.mem_read_en && hit) begin
      bus.mem_read_data <= mem[idx];
    end else begin
      bus.mem_read_data <= bus.mem_read_data;
    end
  end

endmodule

// File: rtl/lsu_align.sv
// Combinational byte-lane logic: load extraction with sign/zero extension and
// sub-word store merge into a captured doubleword.
module lsu_align
  import lsu_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [2:0]      funct3,
  input  logic [2:0]      offset,
  input  logic [XLEN-1:0] mem_data,
  input  logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] load_data,
  output logic [XLEN-1:0] merged_data
);

  logic [XLEN-1:0] shifted;
  logic [XLEN-1:0] wshift;
  logic [7:0]      lane_mask;

  // Right-justify the addressed field, then extend per funct3[2].
  always_comb begin
    shifted   = mem_data >> {offset, 3'b000};
    load_data = '0;
    case (funct3[1:0])
      2'b00: load_data = funct3[2] ? {{(XLEN-8){1'b0}}, shifted[7:0]}
                                   : {{(XLEN-8){shifted[7]}}, shifted[7:0]};
      2'b01: load_data = funct3[2] ? {{(XLEN-16){1'b0}}, shifted[15:0]}
                                   : {{(XLEN-16){shifted[15]}}, shifted[15:0]};
      2'b10: load_data = funct3[2] ? {{(XLEN-32){1'b0}}, shifted[31:0]}
                                   : {{(XLEN-32){shifted[31]}}, shifted[31:0]};
      2'b11: load_data = shifted;
      default: load_data = '0;
    endcase
  end

  // Replace only the addressed byte lanes with the low bytes of the store data.
  always_comb begin
    lane_mask   = size_mask(funct3[1:0]) << offset;
    wshift      = wdata << {offset, 3'b000};
    merged_data = mem_data;
    for (int i = 0; i < XLEN / 8; i++) begin
      if (lane_mask[i]) begin
        merged_data[8*i +: 8] = wshift[8*i +: 8];
      end else begin
        merged_data[8*i +: 8] = mem_data[8*i +: 8];
      end
    end
  end

endmodule

// File: rtl/load_store_unit.sv
// RISC-V style load/store unit: one request at a time, read-modify-write for
// sub-word stores, fault detection before any memory access.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_write,
  input  logic [2:0]      req_funct3,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            resp_valid,
  output logic [XLEN-1:0] resp_rdata,
  output logic            resp_fault,
  output logic [XLEN-1:0] mem_address,
  output logic [XLEN-1:0] mem_write_data,
  output logic            mem_write_en,
  output logic            mem_read_en,
  input  logic [XLEN-1:0] mem_read_data
);

  lsu_state_t      state;
  logic            held_write;
  logic [2:0]      held_funct3;
  logic [XLEN-1:0] held_addr;
  logic [XLEN-1:0] held_wdata;
  logic [XLEN-1:0] strobe_addr;
  logic            read_strobe;
  logic            write_strobe;
  logic            accept_fault;
  logic [XLEN-1:0] load_data;
  logic [XLEN-1:0] merged_data;

  assign accept_fault = req_fault(req_write, req_funct3, req_addr[2:0]);

  lsu_align #(.XLEN(XLEN)) u_align (
    .funct3      (held_funct3),
    .offset      (held_addr[2:0]),
    .mem_data    (mem_read_data),
    .wdata       (held_wdata),
    .load_data   (load_data),
    .merged_data (merged_data)
  );

  // Reset gates the strobes immediately so a WRITE cycle hit by reset stores nothing.
  assign req_ready    = (state == ST_IDLE);
  assign mem_read_en  = read_strobe & rstn;
  assign mem_write_en = write_strobe & rstn;
  assign mem_address  = rstn ? strobe_addr : '0;

  // Request FSM with all response and memory-side outputs registered.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state          <= ST_IDLE;
      held_write     <= 1'b0;
      held_funct3    <= 3'b000;
      held_addr      <= '0;
      held_wdata     <= '0;
      strobe_addr    <= '0;
      read_strobe    <= 1'b0;
      write_strobe   <= 1'b0;
      mem_write_data <= '0;
      resp_valid     <= 1'b0;
      resp_rdata     <= '0;
      resp_fault     <= 1'b0;
    end else begin
      read_strobe    <= 1'b0;
      write_strobe   <= 1'b0;
      strobe_addr    <= '0;
      mem_write_data <= '0;
      resp_valid     <= 1'b0;
      resp_rdata     <= '0;
      resp_fault     <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            held_write  <= req_write;
            held_funct3 <= req_funct3;
            held_addr   <= req_addr;
            held_wdata  <= req_wdata;
            if (accept_fault) begin
              state      <= ST_RESP;
              resp_valid <= 1'b1;
              resp_fault <= 1'b1;
            end else if (req_write && (req_funct3 == F3_D)) begin
              state          <= ST_WRITE;
              write_strobe   <= 1'b1;
              mem_write_data <= req_wdata;
              strobe_addr    <= {req_addr[XLEN-1:3], 3'b000};
            end else begin
              state       <= ST_READ;
              read_strobe <= 1'b1;
              strobe_addr <= {req_addr[XLEN-1:3], 3'b000};
            end
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_READ: begin
          state <= ST_CAPTURE;
        end
        ST_CAPTURE: begin
          if (held_write) begin
            state          <= ST_WRITE;
            write_strobe   <= 1'b1;
            mem_write_data <= merged_data;
            strobe_addr    <= {held_addr[XLEN-1:3], 3'b000};
          end else begin
            state      <= ST_RESP;
            resp_valid <= 1'b1;
            resp_rdata <= load_data;
          end
        end
        ST_WRITE: begin
          state      <= ST_RESP;
          resp_valid <= 1'b1;
        end
        ST_RESP: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit paired with data_memory.
module tb_load_store_unit;
  import lsu_pkg::*;

  typedef struct {
    logic [63:0] rdata;
    logic        fault;
    int          lat;
    int          rd;
    int          wr;
  } exp_t;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  exp_t sb[$];
  int n_checks = 0;
  int n_fails = 0;
  logic [63:0] cur_addr = 64'd0;

  always #5 clk = ~clk;

  lsu_if #(.XLEN(64)) bus ();

  load_store_unit #(.XLEN(64)) dut (
    .clk            (clk),
    .rstn           (rstn),
    .req_valid      (bus.req_valid),
    .req_ready      (bus.req_ready),
    .req_write      (bus.req_write),
    .req_funct3     (bus.req_funct3),
    .req_addr       (bus.req_addr),
    .req_wdata      (bus.req_wdata),
    .resp_valid     (bus.resp_valid),
    .resp_rdata     (bus.resp_rdata),
    .resp_fault     (bus.resp_fault),
    .mem_address    (bus.mem_address),
    .mem_write_data (bus.mem_write_data),
    .mem_write_en   (bus.mem_write_en),
    .mem_read_en    (bus.mem_read_en),
    .mem_read_data  (bus.mem_read_data)
  );

  data_memory #(.XLEN(64)) u_mem (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus.mem_side)
  );

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%h, expected 0x%h", tag, obs, exp);
    end
  endtask

  // Per-cycle memory-bus checks while a request is in flight; counts strobes.
  task automatic sample_bus(inout int rd, inout int wr);
    logic any;
    any = bus.mem_read_en | bus.mem_write_en;
    if (any) check_val("strobe_excl", {63'd0, bus.mem_read_en & bus.mem_write_en}, 64'd0);
    check_val("mem_addr", bus.mem_address, any ? {cur_addr[63:3], 3'b000} : 64'd0);
    if (bus.mem_read_en) rd++;
    if (bus.mem_write_en) wr++;
  endtask

  task automatic lsu_req(input logic wr, input logic [2:0] f3, input logic [63:0] addr,
                         input logic [63:0] wdata, input logic [63:0] exp_rdata,
                         input logic exp_fault, input logic hold);
    exp_t e;
    exp_t got;
    int lat;
    int rd_n;
    int wr_n;
    int wait_n;
    e.rdata = exp_rdata;
    e.fault = exp_fault;
    e.lat   = exp_fault ? 1 : (wr && f3 == F3_D) ? 2 : !wr ? 3 : 4;
    e.rd    = (exp_fault || (wr && f3 == F3_D)) ? 0 : 1;
    e.wr    = (!exp_fault && wr) ? 1 : 0;
    wait_n = 0;
    while (!bus.req_ready && wait_n < 20) begin
      @(negedge clk);
      wait_n++;
    end
    if (!bus.req_ready) check_val("ready_timeout", 64'd0, 64'd1);
    cur_addr       = addr;
    bus.req_valid  = 1'b1;
    bus.req_write  = wr;
    bus.req_funct3 = f3;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
    sb.push_back(e);
    @(negedge clk);
    lat  = 1;
    rd_n = 0;
    wr_n = 0;
    if (!hold) bus.req_valid = 1'b0;
    while (!bus.resp_valid && lat < 20) begin
      sample_bus(rd_n, wr_n);
      if (hold) begin
        check_val("ready_busy", {63'd0, bus.req_ready}, 64'd0);
        bus.req_addr   = {$urandom, $urandom};
        bus.req_wdata  = {$urandom, $urandom};
        bus.req_funct3 = 3'($urandom_range(0, 7));
        bus.req_write  = ~bus.req_write;
      end
      @(negedge clk);
      lat++;
    end
    sample_bus(rd_n, wr_n);
    if (hold) check_val("ready_in_resp", {63'd0, bus.req_ready}, 64'd0);
    bus.req_valid = 1'b0;
    if (!bus.resp_valid) check_val("resp_timeout", 64'd0, 64'd1);
    got = sb.pop_front();
    check_val("resp_rdata", bus.resp_rdata, got.rdata);
    check_val("resp_fault", {63'd0, bus.resp_fault}, {63'd0, got.fault});
    check_val("latency", 64'(lat), 64'(got.lat));
    check_val("read_strobes", 64'(rd_n), 64'(got.rd));
    check_val("write_strobes", 64'(wr_n), 64'(got.wr));
    @(negedge clk);
    check_val("resp_pulse", {63'd0, bus.resp_valid}, 64'd0);
    check_val("ready_after", {63'd0, bus.req_ready}, 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1);
  end

  initial begin
    int rd_n;
    int wr_n;
    bus.req_valid  = 1'b1;
    bus.req_write  = 1'b1;
    bus.req_funct3 = F3_D;
    bus.req_addr   = 64'h10;
    bus.req_wdata  = 64'hDEAD_BEEF_DEAD_BEEF;
    repeat (3) @(negedge clk);
    check_val("rst_ready", {63'd0, bus.req_ready}, 64'd1);
    check_val("rst_resp_valid", {63'd0, bus.resp_valid}, 64'd0);
    check_val("rst_strobes", {62'd0, bus.mem_read_en, bus.mem_write_en}, 64'd0);
    check_val("rst_mem_addr", bus.mem_address, 64'd0);
    check_val("rst_wdata", bus.mem_write_data, 64'd0);
    bus.req_valid = 1'b0;
    rstn = 1'b1;
    @(negedge clk);
    check_val("no_accept_in_rst", {63'd0, bus.req_ready}, 64'd1);

    lsu_req(1'b1, F3_D,  64'h10, 64'h1122334455667788, 64'h0, 1'b0, 1'b0);
    lsu_req(1'b0, F3_D,  64'h10, 64'h0, 64'h1122334455667788, 1'b0, 1'b0);
    lsu_req(1'b1, F3_B,  64'h13, 64'hAB, 64'h0, 1'b0, 1'b0);
    lsu_req(1'b0, F3_D,  64'h10, 64'h0, 64'h11223344AB667788, 1'b0, 1'b0);
    lsu_req(1'b0, F3_BU, 64'h13, 64'h0, 64'h00000000000000AB, 1'b0, 1'b0);
    lsu_req(1'b0, F3_B,  64'h13, 64'h0, 64'hFFFFFFFFFFFFFFAB, 1'b0, 1'b0);
    lsu_req(1'b0, F3_W,  64'h12, 64'h0, 64'h0, 1'b1, 1'b0);
    lsu_req(1'b1, F3_WU, 64'h10, 64'h55, 64'h0, 1'b1, 1'b0);
    lsu_req(1'b0, F3_ILLEGAL, 64'h10, 64'h0, 64'h0, 1'b1, 1'b0);
    lsu_req(1'b1, F3_D,  64'h11, 64'h77, 64'h0, 1'b1, 1'b0);
    lsu_req(1'b1, F3_D,  64'h10, 64'h8000000000000000, 64'h0, 1'b0, 1'b0);
    lsu_req(1'b0, F3_H,  64'h16, 64'h0, 64'hFFFFFFFFFFFF8000, 1'b0, 1'b0);
    lsu_req(1'b0, F3_HU, 64'h16, 64'h0, 64'h0000000000008000, 1'b0, 1'b0);
    lsu_req(1'b1, F3_H,  64'h12, 64'hFFFF1234, 64'h0, 1'b0, 1'b0);
    lsu_req(1'b0, F3_W,  64'h14, 64'h0, 64'hFFFFFFFF80000000, 1'b0, 1'b0);
    lsu_req(1'b0, F3_WU, 64'h14, 64'h0, 64'h0000000080000000, 1'b0, 1'b0);
    lsu_req(1'b0, F3_D,  64'h10, 64'h0, 64'h8000000012340000, 1'b0, 1'b0);

    // Reset pulse landing on the WRITE cycle of a sub-word store.
    cur_addr       = 64'h10;
    bus.req_valid  = 1'b1;
    bus.req_write  = 1'b1;
    bus.req_funct3 = F3_B;
    bus.req_addr   = 64'h10;
    bus.req_wdata  = 64'hCD;
    @(negedge clk);
    bus.req_valid = 1'b0;
    repeat (2) @(negedge clk);
    check_val("write_before_rst", {63'd0, bus.mem_write_en}, 64'd1);
    rstn = 1'b0;
    #1;
    check_val("write_in_rst", {63'd0, bus.mem_write_en}, 64'd0);
    check_val("addr_in_rst", bus.mem_address, 64'd0);
    @(negedge clk);
    rstn = 1'b1;
    check_val("ready_after_rst", {63'd0, bus.req_ready}, 64'd1);
    rd_n = 0;
    wr_n = 0;
    for (int i = 0; i < 5; i++) begin
      check_val("no_resp_after_rst", {63'd0, bus.resp_valid}, 64'd0);
      sample_bus(rd_n, wr_n);
      @(negedge clk);
    end
    check_val("no_strobes_after_rst", 64'(rd_n + wr_n), 64'd0);
    lsu_req(1'b0, F3_D, 64'h10, 64'h0, 64'h8000000012340000, 1'b0, 1'b0);

    // req_valid held high with inputs scrambled while the request is in flight.
    lsu_req(1'b0, F3_D, 64'h10, 64'h0, 64'h8000000012340000, 1'b0, 1'b1);
    lsu_req(1'b1, F3_B, 64'h17, 64'h5A, 64'h0, 1'b0, 1'b1);
    lsu_req(1'b1, F3_D, 64'h18, 64'h0123456789ABCDEF, 64'h0, 1'b0, 1'b1);
    lsu_req(1'b0, F3_D, 64'h10, 64'h0, 64'h5A00000012340000, 1'b0, 1'b0);
    lsu_req(1'b0, F3_D, 64'h18, 64'h0, 64'h0123456789ABCDEF, 1'b0, 1'b0);

    check_val("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
